// File: rtl/eth_gt_rx_link_supervisor.sv
// RX link supervisor for the GT receive path, running in the 125 MHz init-clock domain.
// It watches GT reset-done, PCS block lock and high-BER, and re-issues an RX datapath
// reset when lock does not arrive or is lost for too long. It also reports debounced
// link state and event counters.
module eth_gt_rx_link_supervisor #(
    parameter int SYNC_STAGES    = 3,
    parameter int LOCK_TIMEOUT   = 125000,
    parameter int DEBOUNCE       = 1250,
    parameter int HIGH_BER_LIMIT = 12500,
    parameter int RESET_PULSE    = 16,
    parameter int TIMER_WIDTH    = 24,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clk_125mhz_int,
    input  logic                   gt_tx_reset,
    input  logic                   enable,
    input  logic                   gt_reset_rx_done_in,
    input  logic                   rx_block_lock_in,
    input  logic                   rx_high_ber_in,
    input  logic                   clear_counters,
    output logic                   gt_reset_rx_datapath_out,
    output logic                   link_up,
    output logic [2:0]             state_out,
    output logic [COUNT_WIDTH-1:0] rx_reset_count,
    output logic [COUNT_WIDTH-1:0] link_drop_count
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DONE = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_DEBOUNCE  = 3'd3,
        ST_LINK_UP   = 3'd4,
        ST_RESET     = 3'd5
    } state_t;

    // Terminal timer values: the timer reads N-1 during the N-th cycle spent in a state.
    localparam logic [TIMER_WIDTH-1:0] LOCK_LAST     = TIMER_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] DEBOUNCE_LAST = TIMER_WIDTH'(DEBOUNCE - 1);
    localparam logic [TIMER_WIDTH-1:0] BER_LAST      = TIMER_WIDTH'(HIGH_BER_LIMIT - 1);
    localparam logic [TIMER_WIDTH-1:0] PULSE_LAST    = TIMER_WIDTH'(RESET_PULSE - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX     = '1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX     = '1;

    logic [SYNC_STAGES-1:0] doneSync_q;
    logic [SYNC_STAGES-1:0] lockSync_q;
    logic [SYNC_STAGES-1:0] berSync_q;
    logic                   doneS;
    logic                   lockS;
    logic                   berS;

    state_t                 state_q;
    state_t                 state_d;
    logic [TIMER_WIDTH-1:0] timer_q;
    logic [TIMER_WIDTH-1:0] timer_d;
    logic [COUNT_WIDTH-1:0] rxResetCount_q;
    logic [COUNT_WIDTH-1:0] rxResetCount_d;
    logic [COUNT_WIDTH-1:0] linkDropCount_q;
    logic [COUNT_WIDTH-1:0] linkDropCount_d;
    logic                   linkUp_q;
    logic                   rxReset_q;
    logic                   enterReset;
    logic                   leaveLinkUp;

    assign doneS = doneSync_q[SYNC_STAGES-1];
    assign lockS = lockSync_q[SYNC_STAGES-1];
    assign berS  = berSync_q[SYNC_STAGES-1];

    // Bring the three asynchronous status inputs into the init-clock domain.
    always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
        if (gt_tx_reset) begin
            doneSync_q <= '0;
            lockSync_q <= '0;
            berSync_q  <= '0;
        end else begin
            doneSync_q <= {doneSync_q[SYNC_STAGES-2:0], gt_reset_rx_done_in};
            lockSync_q <= {lockSync_q[SYNC_STAGES-2:0], rx_block_lock_in};
            berSync_q  <= {berSync_q[SYNC_STAGES-2:0], rx_high_ber_in};
        end
    end

    // Next-state decision; enable=0 and a lost reset-done override everything else,
    // and lock loss beats both the lock timeout and the BER limit.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (doneS) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (!doneS)                  state_d = ST_WAIT_DONE;
                    else if (lockS)              state_d = ST_DEBOUNCE;
                    else if (timer_q == LOCK_LAST) state_d = ST_RESET;
                end
                ST_DEBOUNCE: begin
                    if (!doneS)                      state_d = ST_WAIT_DONE;
                    else if (!lockS)                 state_d = ST_WAIT_LOCK;
                    else if (timer_q == DEBOUNCE_LAST) state_d = ST_LINK_UP;
                end
                ST_LINK_UP: begin
                    if (!doneS)                             state_d = ST_WAIT_DONE;
                    else if (!lockS)                        state_d = ST_WAIT_LOCK;
                    else if (berS && (timer_q == BER_LAST)) state_d = ST_RESET;
                end
                ST_RESET: begin
                    if (timer_q == PULSE_LAST) state_d = ST_WAIT_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Shared timer: restarts on every state change, doubles as the BER run length in
    // LINK_UP (cleared whenever BER is low), and saturates instead of wrapping.
    always_comb begin
        timer_d = timer_q + 1'b1;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == ST_LINK_UP) && !berS) begin
            timer_d = '0;
        end else if (timer_q == TIMER_MAX) begin
            timer_d = timer_q;
        end
    end

    // Event counters: a reset is counted on RESET entry, a drop on any exit from LINK_UP;
    // clearing wins over a coincident event and both counters stick at all-ones.
    always_comb begin
        enterReset      = (state_d == ST_RESET) && (state_q != ST_RESET);
        leaveLinkUp     = (state_q == ST_LINK_UP) && (state_d != ST_LINK_UP);
        rxResetCount_d  = rxResetCount_q;
        linkDropCount_d = linkDropCount_q;
        if (clear_counters) begin
            rxResetCount_d  = '0;
            linkDropCount_d = '0;
        end else begin
            if (enterReset && (rxResetCount_q != COUNT_MAX)) begin
                rxResetCount_d = rxResetCount_q + 1'b1;
            end
            if (leaveLinkUp && (linkDropCount_q != COUNT_MAX)) begin
                linkDropCount_d = linkDropCount_q + 1'b1;
            end
        end
    end

    // State, timer, counters and the state-decoded outputs, registered together so the
    // outputs line up with the state they describe.
    always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
        if (gt_tx_reset) begin
            state_q         <= ST_IDLE;
            timer_q         <= '0;
            rxResetCount_q  <= '0;
            linkDropCount_q <= '0;
            linkUp_q        <= 1'b0;
            rxReset_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            rxResetCount_q  <= rxResetCount_d;
            linkDropCount_q <= linkDropCount_d;
            linkUp_q        <= (state_d == ST_LINK_UP);
            rxReset_q       <= (state_d == ST_RESET);
        end
    end

    assign gt_reset_rx_datapath_out = rxReset_q;
    assign link_up                  = linkUp_q;
    assign state_out                = state_q;
    assign rx_reset_count           = rxResetCount_q;
    assign link_drop_count          = linkDropCount_q;

endmodule

// File: tb/tb_eth_gt_rx_link_supervisor.sv
// Testbench for eth_gt_rx_link_supervisor: directed bring-up/timeout/BER/abort scenarios
// followed by randomized input runs, all compared against a cycle-level behavioural model.
module tb_eth_gt_rx_link_supervisor;

    localparam int SYNC = 2;
    localparam int LT   = 20;
    localparam int DB   = 5;
    localparam int HBL  = 8;
    localparam int RP   = 4;
    localparam int CW   = 16;
    localparam int NW   = 3;

    localparam int M_IDLE  = 0;
    localparam int M_WDONE = 1;
    localparam int M_WLOCK = 2;
    localparam int M_DEB   = 3;
    localparam int M_UP    = 4;
    localparam int M_RST   = 5;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          enable = 1'b0;
    logic          done   = 1'b0;
    logic          lock   = 1'b0;
    logic          ber    = 1'b0;
    logic          clr    = 1'b0;

    logic          pulseW, linkW, pulseN, linkN;
    logic [2:0]    stateW, stateN;
    logic [CW-1:0] rxW, dropW;
    logic [NW-1:0] rxN, dropN;

    int checks = 0;
    int fails  = 0;

    // Model view: state, cycles spent in it, BER run, counters, input history.
    int mSt = 0, mAge = 0, mBerRun = 0;
    int mRx = 0, mDrop = 0, mRxN = 0, mDropN = 0;
    bit hDone[SYNC];
    bit hLock[SYNC];
    bit hBer[SYNC];

    eth_gt_rx_link_supervisor #(
        .SYNC_STAGES(SYNC), .LOCK_TIMEOUT(LT), .DEBOUNCE(DB), .HIGH_BER_LIMIT(HBL),
        .RESET_PULSE(RP), .TIMER_WIDTH(24), .COUNT_WIDTH(CW)
    ) dut (
        .clk_125mhz_int(clk), .gt_tx_reset(rst), .enable(enable),
        .gt_reset_rx_done_in(done), .rx_block_lock_in(lock), .rx_high_ber_in(ber),
        .clear_counters(clr), .gt_reset_rx_datapath_out(pulseW), .link_up(linkW),
        .state_out(stateW), .rx_reset_count(rxW), .link_drop_count(dropW)
    );

    eth_gt_rx_link_supervisor #(
        .SYNC_STAGES(SYNC), .LOCK_TIMEOUT(LT), .DEBOUNCE(DB), .HIGH_BER_LIMIT(HBL),
        .RESET_PULSE(RP), .TIMER_WIDTH(24), .COUNT_WIDTH(NW)
    ) dutSat (
        .clk_125mhz_int(clk), .gt_tx_reset(rst), .enable(enable),
        .gt_reset_rx_done_in(done), .rx_block_lock_in(lock), .rx_high_ber_in(ber),
        .clear_counters(clr), .gt_reset_rx_datapath_out(pulseN), .link_up(linkN),
        .state_out(stateN), .rx_reset_count(rxN), .link_drop_count(dropN)
    );

    always #4 clk = ~clk;

    task automatic applyStimulus(input bit en, input bit dn, input bit lk, input bit br, input bit cl);
        enable = en;
        done   = dn;
        lock   = lk;
        ber    = br;
        clr    = cl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic waitState(input logic [2:0] s, input int budget, output int cycles);
        cycles = 0;
        while ((stateW !== s) && (cycles < budget)) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("wait_state", {29'd0, stateW}, {29'd0, s});
    endtask

    function automatic int satInc(input int v, input int w);
        return (v >= (1 << w) - 1) ? v : v + 1;
    endfunction

    // One clock of the supervisor's rules, seen through an N-cycle input delay.
    task automatic modelStep();
        bit dS, lS, bS;
        int nxt;
        dS = hDone[SYNC-1];
        lS = hLock[SYNC-1];
        bS = hBer[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) begin
            hDone[i] = hDone[i-1];
            hLock[i] = hLock[i-1];
            hBer[i]  = hBer[i-1];
        end
        hDone[0] = done;
        hLock[0] = lock;
        hBer[0]  = ber;
        if (mSt == M_UP) mBerRun = bS ? mBerRun + 1 : 0;
        nxt = mSt;
        if (!enable) nxt = M_IDLE;
        else if (mSt == M_IDLE) nxt = M_WDONE;
        else if (mSt == M_WDONE) begin
            if (dS) nxt = M_WLOCK;
        end else if (mSt == M_RST) begin
            if (mAge == RP) nxt = M_WDONE;
        end else if (!dS) nxt = M_WDONE;
        else if (mSt == M_WLOCK) begin
            if (lS) nxt = M_DEB;
            else if (mAge == LT) nxt = M_RST;
        end else if (!lS) nxt = M_WLOCK;
        else if (mSt == M_DEB) begin
            if (mAge == DB) nxt = M_UP;
        end else if (mSt == M_UP) begin
            if (mBerRun == HBL) nxt = M_RST;
        end
        if (clr) begin
            mRx = 0; mDrop = 0; mRxN = 0; mDropN = 0;
        end else begin
            if (nxt == M_RST && mSt != M_RST) begin
                mRx = satInc(mRx, CW); mRxN = satInc(mRxN, NW);
            end
            if (mSt == M_UP && nxt != M_UP) begin
                mDrop = satInc(mDrop, CW); mDropN = satInc(mDropN, NW);
            end
        end
        if (nxt != mSt) begin
            mAge = 1; mBerRun = 0;
        end else begin
            mAge++;
        end
        mSt = nxt;
    endtask

    // Model process: clears on reset, otherwise advances one step per rising edge.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mSt = M_IDLE; mAge = 0; mBerRun = 0;
            mRx = 0; mDrop = 0; mRxN = 0; mDropN = 0;
            for (int i = 0; i < SYNC; i++) begin
                hDone[i] = 1'b0; hLock[i] = 1'b0; hBer[i] = 1'b0;
            end
        end else begin
            modelStep();
        end
    end

    // Compare process: every falling edge, both instances against the model.
    initial forever begin
        @(negedge clk);
        checkOutput("state",     {29'd0, stateW}, mSt);
        checkOutput("link_up",   {31'd0, linkW}, (mSt == M_UP) ? 1 : 0);
        checkOutput("rx_reset",  {31'd0, pulseW}, (mSt == M_RST) ? 1 : 0);
        checkOutput("rx_count",  {16'd0, rxW}, mRx);
        checkOutput("drop_count", {16'd0, dropW}, mDrop);
        checkOutput("sat_state", {29'd0, stateN}, mSt);
        checkOutput("sat_rx_count", {29'd0, rxN}, mRxN);
        checkOutput("sat_drop_count", {29'd0, dropN}, mDropN);
    end

    initial begin
        int  n;
        bit  sawLink, sawRst;
        int  rx0;
        bit  rEn, rDn, rLk, rBr;
        int  enRun, dnRun, lkRun, brRun;

        applyStimulus(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("reset_state", {29'd0, stateW}, 0);
        checkOutput("reset_link", {31'd0, linkW}, 0);
        checkOutput("reset_pulse", {31'd0, pulseW}, 0);
        checkOutput("reset_rx", {16'd0, rxW}, 0);
        rst = 1'b0;

        // Normal bring-up.
        applyStimulus(1, 1, 1, 0, 0);
        waitState(3'd3, 40, n);
        waitState(3'd4, 20, n);
        checkOutput("debounce_len", n, DB);
        checkOutput("bringup_link", {31'd0, linkW}, 1);
        checkOutput("bringup_rx", {16'd0, rxW}, 0);
        checkOutput("bringup_drop", {16'd0, dropW}, 0);

        // Lock timeout, pulse width and repeated timeouts.
        applyStimulus(1, 1, 0, 0, 0);
        waitState(3'd2, 10, n);
        waitState(3'd5, 40, n);
        checkOutput("timeout_len", n, LT);
        n = 0;
        while (pulseW === 1'b1 && n < 10) begin
            n++;
            @(negedge clk);
        end
        checkOutput("pulse_len", n, RP);
        checkOutput("rx_after_1", {16'd0, rxW}, 1);
        checkOutput("drop_after_loss", {16'd0, dropW}, 1);
        n = 0;
        while (rxW < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rx_after_3", {16'd0, rxW}, 3);

        // Lock bouncing 3 high / 1 low: never up, never times out.
        waitState(3'd2, 40, n);
        rx0 = rxW;
        sawLink = 0;
        sawRst = 0;
        for (int c = 0; c < 64; c++) begin
            applyStimulus(1, 1, (c % 4) != 3, 0, 0);
            @(negedge clk);
            if (linkW === 1'b1) sawLink = 1;
            if (stateW === 3'd5) sawRst = 1;
        end
        checkOutput("bounce_link", {31'd0, sawLink}, 0);
        checkOutput("bounce_reset", {31'd0, sawRst}, 0);
        checkOutput("bounce_rx", {16'd0, rxW}, rx0);

        // High BER: a 7-cycle run is tolerated, an 8-cycle run forces a reset.
        applyStimulus(1, 1, 1, 0, 0);
        waitState(3'd4, 40, n);
        applyStimulus(1, 1, 1, 0, 1);
        @(negedge clk);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("clear_rx", {16'd0, rxW}, 0);
        checkOutput("clear_drop", {16'd0, dropW}, 0);
        applyStimulus(1, 1, 1, 1, 0);
        repeat (7) @(negedge clk);
        applyStimulus(1, 1, 1, 0, 0);
        repeat (4) @(negedge clk);
        checkOutput("ber7_state", {29'd0, stateW}, 4);
        applyStimulus(1, 1, 1, 1, 0);
        repeat (8) @(negedge clk);
        applyStimulus(1, 1, 1, 0, 0);
        waitState(3'd5, 6, n);
        checkOutput("ber8_delay", n, 2);
        checkOutput("ber_rx", {16'd0, rxW}, 1);
        checkOutput("ber_drop", {16'd0, dropW}, 1);

        // Counter saturation on the narrow instance, then clear against an increment.
        applyStimulus(1, 1, 0, 0, 1);
        @(negedge clk);
        applyStimulus(1, 1, 0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            n = 0;
            while (stateW === 3'd5 && n < 10) begin
                @(negedge clk);
                n++;
            end
            waitState(3'd5, 40, n);
        end
        checkOutput("sat_wide_rx", {16'd0, rxW}, 9);
        checkOutput("sat_narrow_rx", {29'd0, rxN}, 7);
        n = 0;
        while (stateW === 3'd5 && n < 10) begin
            @(negedge clk);
            n++;
        end
        waitState(3'd2, 10, n);
        repeat (LT - 1) @(negedge clk);
        applyStimulus(1, 1, 0, 0, 1);
        @(negedge clk);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("clr_vs_inc_state", {29'd0, stateW}, 5);
        checkOutput("clr_vs_inc_rx", {16'd0, rxW}, 0);
        checkOutput("clr_vs_inc_rxn", {29'd0, rxN}, 0);

        // Abort a pulse with enable=0 during its second cycle.
        @(negedge clk);
        checkOutput("abort_pulse_before", {31'd0, pulseW}, 1);
        applyStimulus(0, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("abort_state", {29'd0, stateW}, 0);
        checkOutput("abort_pulse", {31'd0, pulseW}, 0);

        // Asynchronous reset while the link is up.
        applyStimulus(1, 1, 1, 0, 0);
        waitState(3'd4, 40, n);
        applyStimulus(1, 1, 0, 0, 0);
        repeat (3) @(negedge clk);
        applyStimulus(1, 1, 1, 0, 0);
        waitState(3'd4, 40, n);
        checkOutput("drop_before_arst", {16'd0, dropW}, 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_state", {29'd0, stateW}, 0);
        checkOutput("arst_link", {31'd0, linkW}, 0);
        checkOutput("arst_pulse", {31'd0, pulseW}, 0);
        checkOutput("arst_drop", {16'd0, dropW}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized run-length stimulus.
        rEn = 1; enRun = $urandom_range(200, 800);
        rDn = 1; dnRun = $urandom_range(100, 600);
        rLk = 1; lkRun = $urandom_range(1, 60);
        rBr = 0; brRun = $urandom_range(1, 30);
        for (int c = 0; c < 5000; c++) begin
            if (enRun == 0) begin
                rEn = !rEn;
                enRun = rEn ? $urandom_range(200, 800) : $urandom_range(1, 10);
            end
            if (dnRun == 0) begin
                rDn = !rDn;
                dnRun = rDn ? $urandom_range(100, 600) : $urandom_range(1, 6);
            end
            if (lkRun == 0) begin
                rLk = !rLk;
                lkRun = rLk ? $urandom_range(1, 60) : $urandom_range(1, 28);
            end
            if (brRun == 0) begin
                rBr = !rBr;
                brRun = rBr ? $urandom_range(1, 12) : $urandom_range(1, 30);
            end
            applyStimulus(rEn, rDn, rLk, rBr, $urandom_range(0, 199) == 0);
            if (c == 2500) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
            @(negedge clk);
            enRun--; dnRun--; lkRun--; brRun--;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
